spi_master_shift: RTL and testbench
===================================

Name: spi_master_shift

Overview:
- SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first, single slave select.
- Sits directly downstream of the SPI clock-enable divider; each spi_clk_en pulse marks one SCLK half-period.
- Accepts a parallel word from the protocol-conversion controller with a start/busy/done handshake.
- Serialises the word on mosi while capturing miso, and returns the received word.

Parameters:
- DATA_WIDTH, 8, bits per transfer (legal range 2..32).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- spi_clk_en  input  1  one-clk-wide tick from the divider; one tick = one SCLK half-period.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  DATA_WIDTH  word to send; latched on start acceptance.
- rx_data  output  DATA_WIDTH  last received word; updated with done.
- busy  output  1  high from start acceptance until the cycle done is high.
- done  output  1  one-clk pulse at transfer end.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  master out.
- miso  input  1  slave in.
- cs_n  output  1  active-low chip select.

Behaviour:
- Reset (async assert, any state): state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, shift registers and edge counter=0. A transfer in progress is abandoned and produces no done.
- All outputs are registered. No combinational path from an input to an output.
- IDLE:
  - spi_clk_en is ignored.
  - If start=1:
    - tx_shift<=tx_data; mosi<=tx_data[DATA_WIDTH-1]
    - cs_n<=0; busy<=1; edge counter<=0
    - go to SETUP.
  - A tick arriving in the same cycle as start is not counted.
- SETUP: wait for the next tick, then go to XFER. sclk remains 0, so there is one full half-period of MOSI setup before the first rising edge.
- XFER: each tick toggles sclk.
  - Rising edge (sclk 0->1): rx_shift<={rx_shift[DATA_WIDTH-2:0], miso}.
  - Falling edge (sclk 1->0):
    - If it is not the last bit: tx_shift shifts left and mosi<=next bit.
    - On the last falling edge (after DATA_WIDTH rising edges): mosi is held and the state goes to HOLD.
  - XFER lasts exactly 2*DATA_WIDTH ticks.
- HOLD: on the next tick:
  - cs_n<=1; rx_data<=rx_shift
  - done<=1 for exactly one clk; busy<=0; mosi<=0
  - go to IDLE.
- Latency:
  - A transfer spans 2*DATA_WIDTH+2 ticks after acceptance.
  - With tick period D clocks, done is seen between (2*DATA_WIDTH+1)*D+1 and (2*DATA_WIDTH+2)*D+1 clocks after start is sampled.
- start while busy is ignored. Neither tx_data nor any register changes.
- Back-to-back: start may be high in the cycle done is high. The cycle done is high is an IDLE cycle, so start is accepted there and cs_n returns low on the following edge. Minimum cs_n high time is 1 clk.
- rx_data holds its value between transfers. Changes to tx_data after acceptance have no effect.
- Edge counter width is clog2(2*DATA_WIDTH)+1. It never wraps within a transfer.

Test Plan:
- Loopback (miso=mosi), divider tick every 4 clk, tx_data=8'hA5 -> exactly 8 sclk rising edges, cs_n low throughout, rx_data=8'hA5, done high 1 clk, busy falls in the same cycle.
- miso tied 1, tx_data=8'h00 -> mosi 0 for whole frame, rx_data=8'hFF. Then miso tied 0, tx_data=8'hFF -> rx_data=8'h00.
- start with 8'h3C issued mid-transfer of 8'h81 (loopback) -> ignored, only one done, rx_data=8'h81, sclk rising-edge count=8.
- rst_n pulsed low after 3 rising edges -> immediately cs_n=1, sclk=0, busy=0, no done. Next loopback transfer 8'h5A -> rx_data=8'h5A.
- start asserted in the done cycle (8'h12 then 8'h34, loopback) -> cs_n high exactly 1 clk between frames, rx_data=8'h12 then 8'h34.
- start coincident with a spi_clk_en tick -> first sclk rise occurs 2 ticks later, not 1. mosi=MSB stable for ≥1 full tick before the first rise.

Source files
------------

// File: rtl/spi_master_shift_if.sv
// Bus bundle between the SPI shift engine, its controller/divider side and the
// SPI pins.
//   slave  : shift engine view (takes tick/start/tx_data/miso, drives the rest)
//   master : controller / bench view (mirror image)
//   spi_clk_en : divider tick, one SCLK half-period per pulse
//   start, tx_data, busy, done, rx_data : word handshake
//   sclk, mosi, miso, cs_n : SPI pins
interface spi_master_shift_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  spi_clk_en;
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport slave (
        input  spi_clk_en, start, tx_data, miso,
        output rx_data, busy, done, sclk, mosi, cs_n
    );

    modport master (
        output spi_clk_en, start, tx_data, miso,
        input  rx_data, busy, done, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_shift.sv
// SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first, one slave select.
// Each spi_clk_en tick is one SCLK half-period. A word accepted on start is
// shifted out on mosi while miso is captured on every SCLK rising edge.
// Ports:
//   clk    : system clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   io_bus : spi_master_shift_if.slave (tick, handshake, SPI pins); all
//            outputs are registered
module spi_master_shift #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_master_shift_if.slave     io_bus
);
    localparam int unsigned       CNT_W     = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_EDGE = CNT_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD
    } state_t;

    state_t                r_state;
    // Only the bits still to be sent after the MSB; the MSB goes straight to mosi.
    logic [DATA_WIDTH-2:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [CNT_W-1:0]      r_edge_cnt;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_done;

    // Transfer sequencer and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ticks are ignored here, so a tick coincident with start is not counted.
                    if (io_bus.start) begin
                        r_tx_shift <= io_bus.tx_data[DATA_WIDTH-2:0];
                        r_mosi     <= io_bus.tx_data[DATA_WIDTH-1];
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_edge_cnt <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // One full half-period of MOSI setup before the first rising edge.
                    if (io_bus.spi_clk_en) begin
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (io_bus.spi_clk_en) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                        if (!r_sclk) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], io_bus.miso};
                        end else if (r_edge_cnt == LAST_EDGE) begin
                            // Last falling edge: keep mosi and close the frame on the next tick.
                            r_state <= S_HOLD;
                        end else begin
                            r_mosi     <= r_tx_shift[DATA_WIDTH-2];
                            r_tx_shift <= r_tx_shift << 1;
                        end
                    end
                end
                S_HOLD: begin
                    if (io_bus.spi_clk_en) begin
                        r_cs_n    <= 1'b1;
                        r_rx_data <= r_rx_shift;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_mosi    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.rx_data = r_rx_data;
    assign io_bus.busy    = r_busy;
    assign io_bus.done    = r_done;
    assign io_bus.sclk    = r_sclk;
    assign io_bus.mosi    = r_mosi;
    assign io_bus.cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_shift.sv
// Bench for spi_master_shift: directed scenarios plus randomized frames,
// checked against an SPI mode-0 slave model and word-level expectations.
module tb_spi_master_shift;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_master_shift_if #(.DATA_WIDTH(W)) bus ();

    spi_master_shift #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned start_cyc = 0;
    int          tick_period = 4;
    int          tcnt = 0;

    // Slave model: loopback, or shifts slave_word out MSB first (mode 0)
    logic         loop = 1'b1;
    logic         slave_miso = 1'b0;
    logic [W-1:0] slave_word = '0;
    assign bus.miso = loop ? bus.mosi : slave_miso;

    // Divider model: one tick every tick_period clocks
    initial begin
        bus.spi_clk_en = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tcnt++;
            if (tcnt >= tick_period) begin
                tcnt = 0;
                bus.spi_clk_en = 1'b1;
            end else begin
                bus.spi_clk_en = 1'b0;
            end
        end
    end

    // Pin monitor / slave model
    int           rise_cnt = 0;
    int           done_cnt = 0;
    int           proto_err = 0;
    int           slave_idx = 0;
    logic [W-1:0] mosi_cap = '0;
    int unsigned  first_rise_cyc = 0;
    int unsigned  cs_rise_cyc = 0;
    int unsigned  cs_high_len = 0;
    logic         mosi_moved = 1'b0;
    initial begin
        logic p_sclk, p_cs, p_done, p_busy, p_mosi;
        p_sclk = 1'b0; p_cs = 1'b1; p_done = 1'b0; p_busy = 1'b0; p_mosi = 1'b0;
        forever begin
            @(negedge clk);
            if (p_cs && !bus.cs_n) begin
                rise_cnt    = 0;
                mosi_cap    = '0;
                mosi_moved  = 1'b0;
                slave_idx   = W - 2;
                slave_miso  = slave_word[W-1];
                cs_high_len = cyc - cs_rise_cyc;
            end else if (!bus.cs_n && rise_cnt == 0 && bus.mosi !== p_mosi) begin
                mosi_moved = 1'b1;
            end
            if (!p_sclk && bus.sclk) begin
                rise_cnt++;
                mosi_cap = {mosi_cap[W-2:0], bus.mosi};
                if (rise_cnt == 1) first_rise_cyc = cyc;
            end
            if (p_sclk && !bus.sclk && slave_idx >= 0) begin
                slave_miso = slave_word[slave_idx];
                slave_idx--;
            end
            if (!p_cs && bus.cs_n) cs_rise_cyc = cyc;
            if (bus.sclk && bus.cs_n) proto_err++;
            if (bus.done) begin
                if (p_done || bus.busy || !p_busy) proto_err++;
                done_cnt++;
            end
            p_sclk = bus.sclk; p_cs = bus.cs_n; p_done = bus.done;
            p_busy = bus.busy; p_mosi = bus.mosi;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns one negedge after acceptance
    task automatic start_xfer(input logic [W-1:0] tx);
        bus.tx_data = tx;
        bus.start   = 1'b1;
        @(negedge clk);
        start_cyc   = cyc;
        bus.start   = 1'b0;
        bus.tx_data = W'($urandom());
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check({tag, "_done_timeout"}, 32'(bus.done), 32'd1);
    endtask

    task automatic do_frame(input string tag, input logic [W-1:0] tx,
                            input logic lp, input logic [W-1:0] sw);
        int          d0;
        int unsigned lat, lo, hi;
        logic [W-1:0] exp_rx;
        loop       = lp;
        slave_word = sw;
        exp_rx     = lp ? tx : sw;
        d0         = done_cnt;
        start_xfer(tx);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_cs_n"}, 32'(bus.cs_n), 32'd0);
        wait_done(tag);
        lat = cyc - start_cyc;
        lo  = (2 * W + 1) * tick_period + 1;
        hi  = (2 * W + 2) * tick_period + 1;
        check({tag, "_latency_in_range"}, 32'(lat >= lo && lat <= hi), 32'd1);
        check({tag, "_rx"}, 32'(bus.rx_data), 32'(exp_rx));
        check({tag, "_busy_with_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({tag, "_rises"}, 32'(rise_cnt), 32'(W));
        check({tag, "_slave_rx"}, 32'(mosi_cap), 32'(tx));
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_cs_n_after"}, 32'(bus.cs_n), 32'd1);
    endtask

    initial begin
        int d0, n;
        logic [W-1:0] tx;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(bus.cs_n), 32'd1);
        check("rst_sclk", 32'(bus.sclk), 32'd0);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rx",   32'(bus.rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback A5
        do_frame("loop_a5", 8'hA5, 1'b1, 8'h00);

        // Constant miso
        do_frame("miso1_tx00", 8'h00, 1'b0, 8'hFF);
        do_frame("miso0_txff", 8'hFF, 1'b0, 8'h00);

        // start while busy is ignored
        loop = 1'b1;
        d0 = done_cnt;
        start_xfer(8'h81);
        n = 0;
        while (rise_cnt < 4 && n < 500) begin @(negedge clk); n++; end
        bus.tx_data = 8'h3C;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done("ignore");
        check("ignore_rx", 32'(bus.rx_data), 32'h81);
        @(negedge clk);
        check("ignore_rises", 32'(rise_cnt), 32'(W));
        repeat (100) @(negedge clk);
        check("ignore_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("ignore_idle_busy", 32'(bus.busy), 32'd0);
        check("ignore_rx_held", 32'(bus.rx_data), 32'h81);

        // Reset mid-transfer abandons the frame
        start_xfer(8'hC3);
        n = 0;
        while (rise_cnt < 3 && n < 500) begin @(negedge clk); n++; end
        check("midrst_reached_3_rises", 32'(rise_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 32'(bus.cs_n), 32'd1);
        check("midrst_sclk", 32'(bus.sclk), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (150) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_rx_cleared", 32'(bus.rx_data), 32'd0);
        do_frame("after_rst_5a", 8'h5A, 1'b1, 8'h00);

        // Back-to-back: start in the done cycle
        loop = 1'b1;
        d0 = done_cnt;
        start_xfer(8'h12);
        wait_done("b2b_first");
        check("b2b_rx_first", 32'(bus.rx_data), 32'h12);
        bus.tx_data = 8'h34;
        bus.start   = 1'b1;
        @(negedge clk);
        start_cyc   = cyc;
        bus.start   = 1'b0;
        check("b2b_cs_low_again", 32'(bus.cs_n), 32'd0);
        wait_done("b2b_second");
        check("b2b_rx_second", 32'(bus.rx_data), 32'h34);
        @(negedge clk);
        check("b2b_cs_high_len", 32'(cs_high_len), 32'd1);
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

        // start coincident with a tick: first rise two ticks later
        n = 0;
        while (bus.spi_clk_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("coinc_tick_seen", 32'(bus.spi_clk_en), 32'd1);
        loop = 1'b1;
        start_xfer(8'h96);
        wait_done("coinc");
        check("coinc_rx", 32'(bus.rx_data), 32'h96);
        @(negedge clk);
        check("coinc_first_rise", 32'(first_rise_cyc - start_cyc), 32'(2 * tick_period));
        check("coinc_mosi_stable", 32'(mosi_moved), 32'd0);
        check("coinc_first_bit", 32'(mosi_cap[W-1]), 32'd1);

        // Randomized frames with random tick period
        for (int i = 0; i < 8; i++) begin
            tick_period = int'($urandom_range(1, 6));
            tcnt = 0;
            tx = W'($urandom());
            do_frame($sformatf("rand%0d", i), tx, 1'($urandom_range(0, 1)), W'($urandom()));
            repeat (int'($urandom_range(0, 5))) @(negedge clk);
        end

        check("protocol_errors", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
